// File: rtl/usart_rx_loader_pkg.sv
// Shared constants, state encodings and baud arithmetic for the UART digest loader.
package usart_rx_loader_pkg;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam int         HASH_BYTES = 16;

  typedef enum logic [1:0] {
    BIT_IDLE,
    BIT_START,
    BIT_DATA,
    BIT_STOP
  } bit_state_t;

  typedef enum logic [1:0] {
    PAR_HUNT,
    PAR_LOAD,
    PAR_CHECK
  } par_state_t;

  // Clocks per UART bit, integer-truncated.
  function automatic int bit_period(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/usart_rx_phy.sv
// 8N1 receiver front end: rx synchroniser, mid-bit timer and bit FSM.
module usart_rx_phy
  import usart_rx_loader_pkg::*;
#(
  parameter int fsm_clk_freq = 16000000,
  parameter int baud_rate    = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       stop_err,
  output logic       line_idle
);

  localparam int BIT_P = bit_period(fsm_clk_freq, baud_rate);
  localparam int TMR_W = $clog2(BIT_P + 1);
  localparam logic [TMR_W-1:0] FULL_LOAD = TMR_W'(BIT_P - 1);
  localparam logic [TMR_W-1:0] HALF_LOAD = TMR_W'(BIT_P / 2 - 1);

  logic             rx_p0, rx_p1, rx_p2;
  bit_state_t       state;
  logic [TMR_W-1:0] timer;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  // p0/p1 resynchronise the line, p2 holds the previous sample for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= BIT_IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
      case (state)
        BIT_IDLE: begin
          if (rx_p2 && !rx_p1) begin
            timer <= HALF_LOAD;
            state <= BIT_START;
          end
        end
        BIT_START: begin
          if (timer == '0) begin
            if (!rx_p1) begin
              timer   <= FULL_LOAD;
              bit_idx <= '0;
              state   <= BIT_DATA;
            end else begin
              state <= BIT_IDLE;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        BIT_DATA: begin
          if (timer == '0) begin
            shreg   <= {rx_p1, shreg[7:1]};
            timer   <= FULL_LOAD;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= BIT_STOP;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        BIT_STOP: begin
          // Leave straight after the mid-stop sample so the next start edge is caught.
          if (timer == '0) begin
            if (rx_p1) begin
              rx_byte    <= shreg;
              byte_valid <= 1'b1;
            end else begin
              stop_err <= 1'b1;
            end
            state <= BIT_IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= BIT_IDLE;
      endcase
    end
  end

  assign line_idle = (state == BIT_IDLE);

endmodule

// File: rtl/usart_rx_loader.sv
// Frame parser and digest registers for the host-to-rig MD5 target link.
// Define RX_CHECKSUM_EN to require a trailing xor byte after the 16 payload bytes.
module usart_rx_loader
  import usart_rx_loader_pkg::*;
#(
  parameter int fsm_clk_freq = 16000000,
  parameter int baud_rate    = 115200,
  parameter int timeout_bits = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx,
  output logic         rx_led,
  output logic [0:127] target_hash,
  output logic         target_valid,
  output logic         hash_loaded,
  output logic         frame_err
);

  localparam int BIT_P = bit_period(fsm_clk_freq, baud_rate);
  localparam int CLK_W = $clog2(BIT_P + 1);
  localparam int TO_W  = $clog2(timeout_bits + 1);
  localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(BIT_P - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(timeout_bits - 1);
  localparam logic [3:0]       LAST_IDX = 4'(HASH_BYTES - 1);

  logic [7:0]       rx_byte;
  logic             byte_valid, stop_err, line_idle;
  par_state_t       par_state;
  logic [3:0]       idx;
  logic [7:0]       xor_acc;
  logic [0:127]     shadow, shadow_nxt;
  logic [CLK_W-1:0] clk_cnt;
  logic [TO_W-1:0]  bit_cnt;
  logic             in_frame, timeout_hit;

  usart_rx_phy #(
    .fsm_clk_freq(fsm_clk_freq),
    .baud_rate   (baud_rate)
  ) u_phy (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .stop_err  (stop_err),
    .line_idle (line_idle)
  );

  assign rx_led = ~line_idle;

  // Shadow with the incoming byte merged, so a commit on the last payload byte sees it.
  always_comb begin
    shadow_nxt = shadow;
    shadow_nxt[{idx, 3'b000} +: 8] = rx_byte;
  end

  assign in_frame    = (par_state != PAR_HUNT);
  assign timeout_hit = in_frame && line_idle && !byte_valid &&
                       (clk_cnt == CLK_LAST) && (bit_cnt == TO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else if (!in_frame || byte_valid) begin
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else if (line_idle) begin
      if (clk_cnt == CLK_LAST) begin
        clk_cnt <= '0;
        bit_cnt <= bit_cnt + 1'b1;
      end else begin
        clk_cnt <= clk_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_state    <= PAR_HUNT;
      idx          <= '0;
      xor_acc      <= '0;
      shadow       <= '0;
      target_hash  <= '0;
      target_valid <= 1'b0;
      hash_loaded  <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      target_valid <= 1'b0;
      frame_err    <= 1'b0;
      if (stop_err) begin
        frame_err <= 1'b1;
        par_state <= PAR_HUNT;
      end else if (byte_valid) begin
        case (par_state)
          PAR_HUNT: begin
            if (rx_byte == SYNC_BYTE) begin
              idx       <= '0;
              xor_acc   <= '0;
              par_state <= PAR_LOAD;
            end
          end
          PAR_LOAD: begin
            shadow  <= shadow_nxt;
            xor_acc <= xor_acc ^ rx_byte;
            idx     <= idx + 1'b1;
            if (idx == LAST_IDX) begin
`ifdef RX_CHECKSUM_EN
              par_state <= PAR_CHECK;
`else
              target_hash  <= shadow_nxt;
              target_valid <= 1'b1;
              hash_loaded  <= 1'b1;
              par_state    <= PAR_HUNT;
`endif
            end
          end
          PAR_CHECK: begin
            if (rx_byte == xor_acc) begin
              target_hash  <= shadow;
              target_valid <= 1'b1;
              hash_loaded  <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            par_state <= PAR_HUNT;
          end
          default: par_state <= PAR_HUNT;
        endcase
      end else if (timeout_hit) begin
        frame_err <= 1'b1;
        par_state <= PAR_HUNT;
      end
    end
  end

endmodule

// File: tb/tb_usart_rx_loader.sv
// Directed bench for usart_rx_loader at 16 clocks per bit; adapts to RX_CHECKSUM_EN.
module tb_usart_rx_loader;

  localparam int BIT = 16;
  localparam logic [127:0] H0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] H1 = 128'he5021844a2e797612077406d699e5934;
  localparam logic [127:0] H2 = 128'ha5112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         rx = 1'b1;
  logic         rx_led;
  logic [0:127] target_hash;
  logic         target_valid;
  logic         hash_loaded;
  logic         frame_err;

  usart_rx_loader #(
    .fsm_clk_freq(1600),
    .baud_rate   (100),
    .timeout_bits(32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .rx_led      (rx_led),
    .target_hash (target_hash),
    .target_valid(target_valid),
    .hash_loaded (hash_loaded),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int err_cnt = 0;

  always @(negedge clk) begin
    if (target_valid) valid_cnt <= valid_cnt + 1;
    if (frame_err)    err_cnt   <= err_cnt + 1;
  end

  typedef struct {
    logic [127:0] pl;
    int           n;
    bit           bad_xor;
    int           bad_stop;
    bit           glitch;
    int           tail_bits;
    int           exp_valid;
    int           exp_err;
    logic [127:0] exp_hash;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_bits(input int n);
    repeat (n * BIT) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop_ok;
    repeat (BIT) @(negedge clk);
    if (!stop_ok) begin
      rx = 1'b1;
      repeat (2 * BIT) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [127:0] pl, input int n, input bit bad_xor, input int bad_stop);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    send_byte(8'hA5, 1'b1);
    for (int k = 0; k < n; k++) begin
      b = pl[127 - 8*k -: 8];
      x = x ^ b;
      send_byte(b, k != bad_stop);
    end
`ifdef RX_CHECKSUM_EN
    if (n == 16) send_byte(bad_xor ? (x ^ 8'h01) : x, 1'b1);
`else
    if (bad_xor && n < 0) send_byte(x, 1'b1);
`endif
  endtask

  initial begin
    int v_base, e_base;

    vecs[0] = '{H0, 16, 1'b0, -1, 1'b0, 3, 1, 0, H0};
`ifdef RX_CHECKSUM_EN
    vecs[1] = '{H0, 16, 1'b1, -1, 1'b0, 3, 0, 1, H0};
`else
    vecs[1] = '{H0, 16, 1'b1, -1, 1'b0, 3, 1, 0, H0};
`endif
    vecs[2] = '{H1, 16, 1'b0, 5,  1'b0, 3, 0, 1, H0};
    vecs[3] = '{H1, 16, 1'b0, -1, 1'b0, 3, 1, 0, H1};
    vecs[4] = '{H2, 16, 1'b0, -1, 1'b1, 3, 1, 0, H2};
    vecs[5] = '{H1, 4,  1'b0, -1, 1'b0, 40, 0, 1, H2};
    vecs[6] = '{H0, 16, 1'b0, -1, 1'b0, 3, 1, 0, H0};

    repeat (4) @(negedge clk);
    check("reset target_hash", target_hash, 128'h0);
    check("reset target_valid", 128'(target_valid), 128'h0);
    check("reset hash_loaded", 128'(hash_loaded), 128'h0);
    check("reset frame_err", 128'(frame_err), 128'h0);
    check("reset rx_led", 128'(rx_led), 128'h0);
    reset = 1'b1;
    idle_bits(2);

    for (int i = 0; i < 7; i++) begin
      v_base = valid_cnt;
      e_base = err_cnt;
      if (vecs[i].glitch) begin
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        idle_bits(2);
      end
      send_frame(vecs[i].pl, vecs[i].n, vecs[i].bad_xor, vecs[i].bad_stop);
      idle_bits(vecs[i].tail_bits);
      check($sformatf("vec%0d valid pulses", i), 128'(valid_cnt - v_base), 128'(vecs[i].exp_valid));
      check($sformatf("vec%0d frame_err pulses", i), 128'(err_cnt - e_base), 128'(vecs[i].exp_err));
      check($sformatf("vec%0d target_hash", i), target_hash, vecs[i].exp_hash);
      check($sformatf("vec%0d hash_loaded", i), 128'(hash_loaded), 128'h1);
    end

    // Reset pulled in the middle of a frame's payload.
    send_byte(8'hA5, 1'b1);
    for (int k = 0; k < 5; k++) send_byte(H1[127 - 8*k -: 8], 1'b1);
    rx = 1'b0;
    repeat (6) @(negedge clk);
    check("rx_led busy", 128'(rx_led), 128'h1);
    reset = 1'b0;
    #1;
    check("midreset target_hash", target_hash, 128'h0);
    check("midreset target_valid", 128'(target_valid), 128'h0);
    check("midreset hash_loaded", 128'(hash_loaded), 128'h0);
    check("midreset frame_err", 128'(frame_err), 128'h0);
    check("midreset rx_led", 128'(rx_led), 128'h0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    idle_bits(2);
    v_base = valid_cnt;
    e_base = err_cnt;
    send_frame(H1, 16, 1'b0, -1);
    idle_bits(3);
    check("post-reset valid pulses", 128'(valid_cnt - v_base), 128'h1);
    check("post-reset frame_err pulses", 128'(err_cnt - e_base), 128'h0);
    check("post-reset target_hash", target_hash, H1);
    check("post-reset hash_loaded", 128'(hash_loaded), 128'h1);
    check("idle rx_led", 128'(rx_led), 128'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
